// File: rtl/present80_iter_ctrl.sv
// PRESENT-80 round-iterative encryption controller.
// One shared S-box/pLayer round per cycle with valid/ready wrapping.
module present80_iter_ctrl #(
    parameter int unsigned ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] pt,
    input  logic [0:79] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] ct,
    output logic        busy,
    output logic [4:0]  round_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [4:0] LAST   = 5'(ROUNDS);

    logic [1:0]  fsm;
    logic [63:0] st;
    logic [79:0] kreg;
    logic [63:0] ct_q;
    logic [4:0]  rc;
    logic [63:0] next_st;
    logic [79:0] krot;
    logic [79:0] next_k;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++)
            y[4*n +: 4] = sbox4(x[4*n +: 4]);
        return y;
    endfunction

    // Internal vectors use LSB-0 numbering, so the textbook permutation applies directly.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++)
            y[(16 * i) % 63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    always_comb begin
        next_st = p_layer(sbox_layer(st ^ kreg[79:16]));
        krot = {kreg[18:0], kreg[79:19]};
        next_k = krot;
        next_k[79:76] = sbox4(krot[79:76]);
        next_k[19:15] = krot[19:15] ^ rc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm  <= S_IDLE;
            st   <= '0;
            kreg <= '0;
            ct_q <= '0;
            rc   <= '0;
        end else begin
            unique case (fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        st   <= pt;
                        kreg <= key;
                        rc   <= 5'd1;
                        fsm  <= S_RUN;
                    end
                end
                S_RUN: begin
                    st   <= next_st;
                    kreg <= next_k;
                    if (rc == LAST) begin
                        ct_q <= next_st ^ next_k[79:16];
                        rc   <= '0;
                        fsm  <= S_DONE;
                    end else begin
                        rc <= rc + 5'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        fsm <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == S_IDLE);
    assign busy      = (fsm == S_RUN);
    assign out_valid = (fsm == S_DONE);
    assign round_idx = rc;
    assign ct        = ct_q;

endmodule

// File: tb/tb_present80_iter_ctrl.sv
// Scoreboard bench for present80_iter_ctrl using published PRESENT-80 vectors.
module tb_present80_iter_ctrl;

    localparam int ROUNDS = 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:63] pt = '0;
    logic [0:79] key = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [0:63] ct;
    logic        busy;
    logic [4:0]  round_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cur_acc = 0;
    logic ov_prev = 1'b0;

    logic [63:0] q_ct[$];
    int          q_acc[$];

    present80_iter_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pt(pt),
        .key(key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ct(ct),
        .busy(busy),
        .round_idx(round_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, inputs change just after rising edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev <= 1'b0;
        end else begin
            if (busy)
                chk("round_idx", 64'(round_idx), 64'(cyc - cur_acc + 1));
            else
                chk("round_idx_idle", 64'(round_idx), 64'd0);
            if (busy || out_valid)
                chk("in_ready_low", 64'(in_ready), 64'd0);
            if (out_valid) begin
                if (q_ct.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    chk("ct", ct, q_ct[0]);
                    if (!ov_prev)
                        chk("latency", 64'(cyc), 64'(q_acc[0] + ROUNDS));
                    if (out_ready) begin
                        void'(q_ct.pop_front());
                        void'(q_acc.pop_front());
                    end
                end
            end
            ov_prev <= out_valid;
        end
    end

    task automatic send(input logic [63:0] p, input logic [79:0] k,
                        input logic [63:0] exp, input logic hold,
                        output int acc);
        int n;
        n = 0;
        pt = p;
        key = k;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = hold;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            cur_acc = cyc;
            q_ct.push_back(exp);
            q_acc.push_back(cyc);
            in_valid = hold;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_ct.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 64'(q_ct.size()), 64'd0);
    endtask

    initial begin
        int a1;
        int a2;
        int n;

        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_round_idx", 64'(round_idx), 64'd0);
        chk("rst_ct", ct, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1..T3
        send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0, a1);
        drain();
        send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, a1);
        drain();
        send({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b0, a1);
        drain();

        // T4: stalled consumer, in_valid pulses must be ignored
        out_ready = 1'b0;
        send({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0, a1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            pt = 64'h0123456789ABCDEF;
            key = 80'h0;
            in_valid = i[0];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // T5: asynchronous reset mid-run
        send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0, a1);
        n = 0;
        @(negedge clk);
        while (round_idx != 5'd12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_round12", 64'(round_idx), 64'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_ct", ct, 64'd0);
        void'(q_ct.pop_back());
        void'(q_acc.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0, a1);
        drain();

        // T6: back-to-back blocks
        send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b1, a1);
        send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, a2);
        chk("t6_spacing", 64'(a2 - a1), 64'(ROUNDS + 2));
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
